// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM register, data-memory handshake FSM and MEM/WB register.
// Latency: one cycle EX->MEM, one cycle MEM->WB; a memory op may complete in the cycle it is issued.
// Backpressure: stall_M is high while a memory op waits for dm_ack; both pipeline registers then hold or bubble.
module memory_stage #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         flush_M,
    input  logic         RegWrite_E,
    input  logic         MemtoReg_E,
    input  logic         MemRead_E,
    input  logic         MemWrite_E,
    input  logic         Branch_E,
    input  logic         UncondBranch_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic         zero_E,
    input  logic [4:0]   rd_E,
    output logic         stall_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_M,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ack,
    input  logic [N-1:0] dm_rdata,
    output logic         valid_W,
    output logic         RegWrite_W,
    output logic         MemtoReg_W,
    output logic [4:0]   rd_W,
    output logic [N-1:0] aluResult_W,
    output logic [N-1:0] readData_W
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    // EX/MEM register fields
    logic         valid_M_q;
    logic         RegWrite_M_q;
    logic         MemtoReg_M_q;
    logic         MemRead_M_q;
    logic         MemWrite_M_q;
    logic         Branch_M_q;
    logic         UncondBranch_M_q;
    logic         zero_M_q;
    logic [N-1:0] aluResult_M_q;
    logic [N-1:0] writeData_M_q;
    logic [N-1:0] PCBranch_M_q;
    logic [4:0]   rd_M_q;

    // MEM/WB register fields
    logic         valid_W_q;
    logic         RegWrite_W_q;
    logic         MemtoReg_W_q;
    logic [4:0]   rd_W_q;
    logic [N-1:0] aluResult_W_q;
    logic [N-1:0] readData_W_q;

    logic memop;
    logic done;
    logic load_only;

    // A valid instruction that touches memory; a read+write combination is treated as a store
    assign memop     = valid_M_q & (MemRead_M_q | MemWrite_M_q);
    assign load_only = MemRead_M_q & ~MemWrite_M_q;
    assign done      = dm_req & dm_ack;
    assign stall_M   = memop & ~done;

    // Handshake FSM: IDLE issues the request as soon as a memop is present, WAIT keeps it up until ack
    always_comb begin
        state_d = state_q;
        dm_req  = 1'b0;
        case (state_q)
            S_IDLE: begin
                dm_req = memop;
                if (memop && !dm_ack) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                dm_req = 1'b1;
                if (dm_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory-side outputs are driven only while a request is outstanding, zero otherwise
    always_comb begin
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        if (dm_req) begin
            dm_we    = MemWrite_M_q;
            dm_addr  = aluResult_M_q;
            dm_wdata = writeData_M_q;
        end
    end

    // EX/MEM register: capture when not stalled; flush turns the captured slot into a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_M_q        <= 1'b0;
            RegWrite_M_q     <= 1'b0;
            MemtoReg_M_q     <= 1'b0;
            MemRead_M_q      <= 1'b0;
            MemWrite_M_q     <= 1'b0;
            Branch_M_q       <= 1'b0;
            UncondBranch_M_q <= 1'b0;
            zero_M_q         <= 1'b0;
            aluResult_M_q    <= '0;
            writeData_M_q    <= '0;
            PCBranch_M_q     <= '0;
            rd_M_q           <= '0;
        end else if (!stall_M) begin
            valid_M_q        <= valid_E & ~flush_M;
            RegWrite_M_q     <= RegWrite_E;
            MemtoReg_M_q     <= MemtoReg_E;
            MemRead_M_q      <= MemRead_E;
            MemWrite_M_q     <= MemWrite_E;
            Branch_M_q       <= Branch_E;
            UncondBranch_M_q <= UncondBranch_E;
            zero_M_q         <= zero_E;
            aluResult_M_q    <= aluResult_E;
            writeData_M_q    <= writeData_E;
            PCBranch_M_q     <= PCBranch_E;
            rd_M_q           <= rd_E;
        end
    end

    // MEM/WB register: advance when not stalled, otherwise emit a bubble while data fields hold
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_W_q     <= 1'b0;
            RegWrite_W_q  <= 1'b0;
            MemtoReg_W_q  <= 1'b0;
            rd_W_q        <= '0;
            aluResult_W_q <= '0;
            readData_W_q  <= '0;
        end else if (!stall_M) begin
            valid_W_q     <= valid_M_q;
            RegWrite_W_q  <= RegWrite_M_q & valid_M_q;
            MemtoReg_W_q  <= MemtoReg_M_q;
            rd_W_q        <= rd_M_q;
            aluResult_W_q <= aluResult_M_q;
            readData_W_q  <= (done && load_only) ? dm_rdata : '0;
        end else begin
            valid_W_q     <= 1'b0;
            RegWrite_W_q  <= 1'b0;
        end
    end

    assign PCSrc_M     = valid_M_q & (UncondBranch_M_q | (Branch_M_q & zero_M_q));
    assign PCBranch_M  = PCBranch_M_q;
    assign valid_W     = valid_W_q;
    assign RegWrite_W  = RegWrite_W_q;
    assign MemtoReg_W  = MemtoReg_W_q;
    assign rd_W        = rd_W_q;
    assign aluResult_W = aluResult_W_q;
    assign readData_W  = readData_W_q;

endmodule
